// File: rtl/priority_interrupt_controller.sv
// Fixed-priority external interrupt controller with ack/complete handshake.
// Define IRQ_SYNC_EN to add a 2-flop synchroniser on every irqBus line.
module priority_interrupt_controller #(
    parameter int EXT_IRQ_COUNT = 8,
    parameter int CODE_BASE     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [EXT_IRQ_COUNT-1:0] irqBus,
    input  logic [EXT_IRQ_COUNT-1:0] irqEnable,
    input  logic [EXT_IRQ_COUNT-1:0] irqEdge,
    input  logic                     intAck,
    input  logic                     intComplete,
    output logic                     interrupt,
    output logic [30:0]              intCode,
    output logic                     inService
);

    localparam int N = EXT_IRQ_COUNT;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] REQUEST   = 2'd1;
    localparam logic [1:0] SERVICING = 2'd2;

    logic [N-1:0] sIrq;
    logic [N-1:0] prevIrq;
    logic [N-1:0] pending;
    logic [N-1:0] pendingNext;
    logic [N-1:0] eligible;
    logic [N-1:0] ackClr;
    logic [4:0]   curIdx;
    logic [4:0]   sel;
    logic         anyElig;
    logic         curElig;
    logic [1:0]   state;

`ifdef IRQ_SYNC_EN
    logic [N-1:0] sync1;
    logic [N-1:0] sync2;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= irqBus;
            sync2 <= sync1;
        end
    end

    assign sIrq = sync2;
`else
    assign sIrq = irqBus;
`endif

    assign eligible = pending & irqEnable;
    assign anyElig  = |eligible;

    // Lowest index wins; curIdx is matched by compare to stay width-agnostic.
    always_comb begin
        sel     = '0;
        curElig = 1'b0;
        ackClr  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (eligible[i]) sel = 5'(i);
        end
        for (int i = 0; i < N; i++) begin
            if (5'(i) == curIdx) begin
                curElig   = eligible[i];
                ackClr[i] = (state == REQUEST) && intAck;
            end
        end
    end

    // Edge channels: a new rise beats a same-cycle ack clear.
    assign pendingNext =
        (irqEdge & ((pending & ~ackClr) | (sIrq & ~prevIrq))) |
        (~irqEdge & sIrq);

    always_ff @(posedge clk) begin
        if (reset) begin
            prevIrq   <= '0;
            pending   <= '0;
            curIdx    <= '0;
            state     <= IDLE;
            interrupt <= 1'b0;
            intCode   <= '0;
            inService <= 1'b0;
        end else begin
            prevIrq <= sIrq;
            pending <= pendingNext;
            unique case (state)
                IDLE: begin
                    if (anyElig) begin
                        curIdx    <= sel;
                        state     <= REQUEST;
                        interrupt <= 1'b1;
                        intCode   <= 31'(CODE_BASE) + 31'(sel);
                    end
                end
                REQUEST: begin
                    if (intAck) begin
                        state     <= SERVICING;
                        interrupt <= 1'b0;
                        inService <= 1'b1;
                    end else if (!curElig) begin
                        state     <= IDLE;
                        interrupt <= 1'b0;
                        intCode   <= '0;
                    end
                end
                SERVICING: begin
                    if (intComplete) begin
                        state     <= IDLE;
                        inService <= 1'b0;
                        intCode   <= '0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    interrupt <= 1'b0;
                    intCode   <= '0;
                    inService <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_priority_interrupt_controller.sv
// Directed self-checking bench for priority_interrupt_controller.
// Built without IRQ_SYNC_EN; latencies below assume direct sampling.
module tb_priority_interrupt_controller;

    logic        clk;
    logic        reset;
    logic [7:0]  irqBus;
    logic [7:0]  irqEnable;
    logic [7:0]  irqEdge;
    logic        intAck;
    logic        intComplete;
    logic        interrupt;
    logic [30:0] intCode;
    logic        inService;

    int passed;
    int total;

    priority_interrupt_controller #(
        .EXT_IRQ_COUNT(8),
        .CODE_BASE(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .irqBus(irqBus),
        .irqEnable(irqEnable),
        .irqEdge(irqEdge),
        .intAck(intAck),
        .intComplete(intComplete),
        .interrupt(interrupt),
        .intCode(intCode),
        .inService(inService)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        total++;
        if (interrupt !== 1'b0 || intCode !== 31'd0 || inService !== 1'b0)
            $display("FAIL reset_init int=%0b code=%0d svc=%0b exp 0/0/0",
                     interrupt, intCode, inService);
        else passed++;
        irqEdge   = 8'hFF;
        irqEnable = 8'hFF;
        irqBus    = 8'h01;
        tick(2);
        total++;
        if (interrupt !== 1'b1 || intCode !== 31'd16)
            $display("FAIL reset_req int=%0b code=%0d exp 1/16",
                     interrupt, intCode);
        else passed++;
        reset = 1'b1;
        tick(1);
        total++;
        if (interrupt !== 1'b0 || intCode !== 31'd0 || inService !== 1'b0)
            $display("FAIL reset_mid int=%0b code=%0d svc=%0b exp 0/0/0",
                     interrupt, intCode, inService);
        else passed++;
        irqBus = 8'h00;
        tick(1);
        reset = 1'b0;
        tick(3);
        total++;
        if (interrupt !== 1'b0)
            $display("FAIL reset_lost int=%0b exp 0", interrupt);
        else passed++;
    endtask

    task automatic test_masked_edge();
        irqEnable = 8'h00;
        irqEdge   = 8'hFF;
        irqBus    = 8'h08;
        tick(1);
        irqBus = 8'h00;
        tick(2);
        total++;
        if (interrupt !== 1'b0)
            $display("FAIL mask_hold int=%0b exp 0", interrupt);
        else passed++;
        irqEnable = 8'h08;
        tick(1);
        total++;
        if (interrupt !== 1'b1 || intCode !== 31'd19)
            $display("FAIL mask_req int=%0b code=%0d exp 1/19",
                     interrupt, intCode);
        else passed++;
        intAck = 1'b1;
        tick(1);
        intAck = 1'b0;
        total++;
        if (interrupt !== 1'b0 || inService !== 1'b1 || intCode !== 31'd19)
            $display("FAIL mask_ack int=%0b svc=%0b code=%0d exp 0/1/19",
                     interrupt, inService, intCode);
        else passed++;
        intComplete = 1'b1;
        tick(1);
        intComplete = 1'b0;
        total++;
        if (inService !== 1'b0 || intCode !== 31'd0)
            $display("FAIL mask_cmp svc=%0b code=%0d exp 0/0",
                     inService, intCode);
        else passed++;
        tick(2);
        total++;
        if (interrupt !== 1'b0)
            $display("FAIL mask_norereq int=%0b exp 0", interrupt);
        else passed++;
    endtask

    task automatic test_priority();
        irqEnable = 8'hFF;
        irqEdge   = 8'hFF;
        irqBus    = 8'h20;
        tick(2);
        total++;
        if (interrupt !== 1'b1 || intCode !== 31'd21)
            $display("FAIL prio_req int=%0b code=%0d exp 1/21",
                     interrupt, intCode);
        else passed++;
        irqBus      = 8'h22;
        intComplete = 1'b1;
        tick(1);
        intComplete = 1'b0;
        tick(1);
        total++;
        if (interrupt !== 1'b1 || intCode !== 31'd21 || inService !== 1'b0)
            $display("FAIL prio_nopre int=%0b code=%0d svc=%0b exp 1/21/0",
                     interrupt, intCode, inService);
        else passed++;
        intAck = 1'b1;
        tick(1);
        intAck = 1'b0;
        total++;
        if (inService !== 1'b1 || intCode !== 31'd21)
            $display("FAIL prio_ack svc=%0b code=%0d exp 1/21",
                     inService, intCode);
        else passed++;
        intComplete = 1'b1;
        tick(1);
        intComplete = 1'b0;
        tick(1);
        total++;
        if (interrupt !== 1'b1 || intCode !== 31'd17)
            $display("FAIL prio_next int=%0b code=%0d exp 1/17",
                     interrupt, intCode);
        else passed++;
        intAck = 1'b1;
        tick(1);
        intAck      = 1'b0;
        intComplete = 1'b1;
        tick(1);
        intComplete = 1'b0;
        irqBus      = 8'h00;
        tick(2);
        total++;
        if (interrupt !== 1'b0 || inService !== 1'b0)
            $display("FAIL prio_drain int=%0b svc=%0b exp 0/0",
                     interrupt, inService);
        else passed++;
    endtask

    task automatic test_level_withdraw();
        irqEdge   = 8'h00;
        irqEnable = 8'hFF;
        irqBus    = 8'h04;
        tick(2);
        total++;
        if (interrupt !== 1'b1 || intCode !== 31'd18)
            $display("FAIL lvl_req int=%0b code=%0d exp 1/18",
                     interrupt, intCode);
        else passed++;
        irqBus = 8'h00;
        tick(2);
        total++;
        if (interrupt !== 1'b0 || intCode !== 31'd0 || inService !== 1'b0)
            $display("FAIL lvl_wd int=%0b code=%0d svc=%0b exp 0/0/0",
                     interrupt, intCode, inService);
        else passed++;
        intAck = 1'b1;
        tick(1);
        intAck = 1'b0;
        total++;
        if (inService !== 1'b0 || interrupt !== 1'b0)
            $display("FAIL lvl_idleack svc=%0b int=%0b exp 0/0",
                     inService, interrupt);
        else passed++;
    endtask

    task automatic test_level_represent();
        irqEdge = 8'h00;
        irqBus  = 8'h01;
        tick(2);
        total++;
        if (interrupt !== 1'b1 || intCode !== 31'd16)
            $display("FAIL rep_req int=%0b code=%0d exp 1/16",
                     interrupt, intCode);
        else passed++;
        intAck = 1'b1;
        tick(1);
        intAck = 1'b0;
        total++;
        if (interrupt !== 1'b0 || inService !== 1'b1)
            $display("FAIL rep_ack int=%0b svc=%0b exp 0/1",
                     interrupt, inService);
        else passed++;
        intComplete = 1'b1;
        tick(1);
        intComplete = 1'b0;
        total++;
        if (interrupt !== 1'b0 || inService !== 1'b0)
            $display("FAIL rep_cmp int=%0b svc=%0b exp 0/0",
                     interrupt, inService);
        else passed++;
        tick(1);
        total++;
        if (interrupt !== 1'b1 || intCode !== 31'd16)
            $display("FAIL rep_again int=%0b code=%0d exp 1/16",
                     interrupt, intCode);
        else passed++;
        irqBus = 8'h00;
        tick(2);
        total++;
        if (interrupt !== 1'b0)
            $display("FAIL rep_wd int=%0b exp 0", interrupt);
        else passed++;
    endtask

    task automatic test_set_clear();
        irqEdge = 8'hFF;
        irqBus  = 8'h00;
        tick(1);
        irqBus = 8'h10;
        tick(2);
        total++;
        if (interrupt !== 1'b1 || intCode !== 31'd20)
            $display("FAIL sc_req int=%0b code=%0d exp 1/20",
                     interrupt, intCode);
        else passed++;
        irqBus = 8'h00;
        tick(1);
        irqBus = 8'h10;
        intAck = 1'b1;
        tick(1);
        intAck = 1'b0;
        total++;
        if (inService !== 1'b1 || interrupt !== 1'b0)
            $display("FAIL sc_ack svc=%0b int=%0b exp 1/0",
                     inService, interrupt);
        else passed++;
        intComplete = 1'b1;
        tick(1);
        intComplete = 1'b0;
        tick(1);
        total++;
        if (interrupt !== 1'b1 || intCode !== 31'd20)
            $display("FAIL sc_again int=%0b code=%0d exp 1/20",
                     interrupt, intCode);
        else passed++;
        intAck = 1'b1;
        tick(1);
        intAck      = 1'b0;
        intComplete = 1'b1;
        tick(1);
        intComplete = 1'b0;
        tick(2);
        total++;
        if (interrupt !== 1'b0 || inService !== 1'b0)
            $display("FAIL sc_drain int=%0b svc=%0b exp 0/0",
                     interrupt, inService);
        else passed++;
    endtask

    initial begin
        passed      = 0;
        total       = 0;
        reset       = 1'b1;
        irqBus      = 8'h00;
        irqEnable   = 8'h00;
        irqEdge     = 8'h00;
        intAck      = 1'b0;
        intComplete = 1'b0;
        test_reset();
        test_masked_edge();
        test_priority();
        test_level_withdraw();
        test_level_represent();
        test_set_clear();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/priority_interrupt_controller.md
Name: priority_interrupt_controller

Overview:
Parametrised external-interrupt controller between the SoC interrupt sources and the CPU trap logic.
- Captures up to EXT_IRQ_COUNT sources, each individually configurable as edge- or level-triggered.
- Masks sources per channel and selects the lowest-index eligible source (fixed priority).
- Presents the selected source to the core as interrupt/intCode and runs an ack/complete handshake, so only one external interrupt is in service at a time.

Parameters:
EXT_IRQ_COUNT, 8, number of external sources; legal range 1..32.
CODE_BASE, 16, intCode reported for source 0; source i reports CODE_BASE+i. CODE_BASE+EXT_IRQ_COUNT-1 must be < 2^31.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
irqBus  input  EXT_IRQ_COUNT  raw interrupt request lines, active-high.
irqEnable  input  EXT_IRQ_COUNT  per-source enable mask; 1 = may be selected.
irqEdge  input  EXT_IRQ_COUNT  per-source mode; 1 = rising-edge, 0 = level.
intAck  input  1  CPU has taken the trap for the presented code; one-cycle pulse.
intComplete  input  1  handler finished (mret); one-cycle pulse.
interrupt  output  1  registered interrupt request to the CPU.
intCode  output  31  registered cause code of the presented/serviced source.
inService  output  1  high while a claimed interrupt is being serviced.

Behaviour:
- Reset: clears interrupt, intCode, inService, all pending bits, the sample/previous registers and the synchronisers, and sets state=IDLE. Reset is synchronous and takes priority over every other event, including mid-handshake; any pending edges are lost.
- Sampling: sIrq = irqBus after the optional synchroniser. prevIrq <= sIrq every cycle.
- Pending, edge source: pending[i] is set when sIrq[i] & ~prevIrq[i]. It is cleared only by intAck for that source. If a set and a clear for the same source occur in the same cycle, the set wins and pending stays 1.
- Pending, level source: pending[i] <= sIrq[i] every cycle. It is not cleared by intAck.
- Masking: edges are captured regardless of irqEnable. irqEnable gates only selection.
- Mode changes: changing irqEdge[i] takes effect the next cycle. Switching a channel to level mode overwrites its pending bit with the live level.
- Selection: eligible = pending & irqEnable. sel = lowest set index; ties go to the lower index.
- FSM states IDLE, REQUEST, SERVICING.
  - IDLE: interrupt=0, intCode=0, inService=0. If eligible != 0: latch curIdx=sel and go to REQUEST. In REQUEST, interrupt=1 and intCode=CODE_BASE+curIdx (registered, visible the cycle after the decision).
  - REQUEST: interrupt and intCode are held stable even if a higher-priority source becomes eligible; no preemption.
    - On intAck: clear pending[curIdx] if edge mode, then go to SERVICING with interrupt=0, inService=1, intCode retained.
    - Withdrawal: if eligible[curIdx] drops (masked, or level deasserted) without intAck, return to IDLE and drop interrupt next cycle. If both happen in the same cycle, intAck wins.
  - SERVICING: interrupt=0. New events still update pending. On intComplete go to IDLE; inService=0 and intCode=0 next cycle.
- Ignored inputs: intAck outside REQUEST; intComplete outside SERVICING.
- Latency, measured from the first clk edge sampling irqBus[i]=1 with no competition:
  - without synchroniser: interrupt=1 after the 2nd edge;
  - with IRQ_SYNC_EN: after the 4th edge.
  - IDLE after intComplete with another source eligible: interrupt reasserts 2 edges after intComplete is sampled.
- A level source still asserted at intComplete is re-presented; the handler must clear it at the device.

Optional Feature:
IRQ_SYNC_EN. Defined: each irqBus bit passes through a 2-flop synchroniser (reset to 0) before the edge detector, which adds 2 cycles of latency; use this for asynchronous sources. Undefined: irqBus is used directly as sIrq, and the sources must be synchronous to clk.

Test Plan:
Reset/idle: assert reset mid-REQUEST with irqBus=8'h01 (edge) -> next cycle interrupt=0, intCode=0, inService=0; the edge is not re-presented unless a new rising edge occurs.
Edge capture while masked: pulse irqBus[3] for 1 cycle with irqEnable=0, then set irqEnable[3]=1 -> interrupt=1, intCode=19; intAck -> interrupt=0, inService=1; intComplete -> IDLE, no re-request.
Priority/no preemption: irqBus[5] rises, REQUEST with intCode=21; irqBus[1] rises before intAck -> intCode stays 21. After ack and complete, intCode=17 is presented.
Level withdrawal: level source 2 asserted, reaches REQUEST (intCode=18); deassert before intAck -> interrupt=0 within 2 cycles, state IDLE, no ack required.
Level re-present: level source 0 held high through ack and complete -> interrupt reasserts with intCode=16 two edges after intComplete.
Simultaneous set/clear: new rising edge on source 4 in the same cycle as intAck for source 4 -> after intComplete, intCode=20 is presented again.
